itgnet_head: RTL and testbench
==============================

Name: itgnet_head

Overview:
- Per-pixel output head that follows the three-layer feature network in the segmentation pipeline.
- Consumes the streamed UNITS-channel signed fixed-point feature vector with its vcnt/hcnt/enable tag.
- Emits the winning class index (argmax) and a saturated unsigned confidence score for each pixel.
- Adds frame-end detection; per-class histograms are available as an option.
- Generalises the old fixed 12-unit tail to any channel count and any fixed-point format.

Parameters:
- W_HEIGHT, 480: padded frame height in lines; sets the vcnt range.
- W_WIDTH, 640: padded frame width in pixels; sets the hcnt range.
- UNITS, 12: number of feature channels (classes), 2 or more.
- INT_BITW, 5: integer bits of each feature, sign bit included.
- FRAC_BITW, 8: fractional bits of each feature; must satisfy FRAC_BITW >= UINT_BITW.
- UINT_BITW, 8: bit width of the output confidence score.

Ports:
- clock, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- in_enable, input, 1: pixel-valid tag.
- in_feat, input, (INT_BITW+FRAC_BITW)*UNITS: features, declared [0:N-1]; channel 0 is the most-significant slice; each slice is signed two's complement.
- in_vcnt, input, log2(W_HEIGHT): line coordinate.
- in_hcnt, input, log2(W_WIDTH): pixel coordinate.
- out_enable, output, 1: delayed in_enable.
- out_class, output, log2(UNITS): argmax channel index.
- out_score, output, UINT_BITW: confidence of the winning channel.
- out_vcnt, output, log2(W_HEIGHT): delayed line coordinate.
- out_hcnt, output, log2(W_WIDTH): delayed pixel coordinate.
- out_frame_done, output, 1: one-cycle pulse on the last pixel of a frame.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All pipeline registers and all outputs reset to 0.
- Free-running pipeline: no stall and no backpressure. Every stage captures its inputs on every clock edge.
- Enable and tag alignment: in_enable, in_vcnt and in_hcnt travel through a delay line matched to the data path. Outputs for cycles with in_enable=0 carry no meaning; the bench ignores them.
- Comparator tree: D = ceil(log2(UNITS)) registered stages.
- Each tree node compares two (value, index) pairs as signed values. The larger value wins.
- Tie rule: on equal values the lower index wins.
- Padding: when UNITS is not a power of two, inputs are padded with the most-negative value and out-of-range indices. A padded entry can never win.
- Conversion stage: one further registered stage maps the winning value to out_score.
  - Winning value negative: out_score = 0.
  - FRAC_BITW == UINT_BITW: out_score = magnitude bits [FRAC+INT-2:0], saturated to 2^UINT_BITW-1.
  - FRAC_BITW > UINT_BITW: value is shifted right by FRAC-UINT-1, then 1 is added, then it is shifted right by 1 (round half up). The result is then saturated to 2^UINT_BITW-1.
- Total latency: L = D+1 cycles from input to output. For UNITS=12, L = 5.
- Frame done: out_frame_done = out_enable AND out_vcnt==W_HEIGHT-1 AND out_hcnt==W_WIDTH-1. It is asserted in the same cycle as that pixel's out_class.
- Reset during operation: all in-flight pixels are discarded; no partial output and no frame_done pulse is produced. Output restarts L cycles after the first in_enable that follows reset release.
- Consecutive frames: back-to-back frames with no blanking gap are legal. Every frame's last pixel produces its own pulse.

Optional Feature:
- Macro: ITGNET_HEAD_HIST_EN.
- With the macro defined, the block adds:
  - Output port out_hist, width UNITS*CNT_BITW, where CNT_BITW = log2(W_HEIGHT*W_WIDTH+1).
  - Output port out_hist_valid, width 1.
  - One counter per class, incremented when out_enable=1 for that out_class.
  - In the out_frame_done cycle, the counts including that final pixel are snapshotted into out_hist. out_hist_valid pulses one cycle later. The counters clear and the next pixel counts from 0.
  - Reset clears the counters, out_hist and out_hist_valid.
- Without the macro: the ports and counters are absent, and the rest of the behaviour is unchanged.

Decomposition:
- Shared package cnn_pkg holds:
  - function log2 (ceil);
  - localparams FIXED_BITW = INT_BITW+FRAC_BITW and TREE_DEPTH;
  - the fixed-to-uint saturation function, which is also used by future output stages.
- One natural sub-module: argmax_node. It is a single registered compare of two (value, index) pairs with the lower-index tie rule, instantiated in a generate tree.
- The tag delay line reuses the existing delay module.

Test Plan (UNITS=12, INT=5, FRAC=8, UINT=8, W 4x4 unless noted):
1. ch7 = 13'h0040 and all other channels 0, with in_enable pulsed at cycle t -> out_enable=1 at t+5, out_class=7, out_score=64, vcnt/hcnt echoed.
2. Tie: ch3 = ch9 = 13'h0100 and the rest 0 -> out_class=3, out_score=255 (256 saturates).
3. All channels 13'h1F00 (-1.0) except ch11 = 13'h1FFF -> out_class=11, out_score=0.
4. FRAC=10 build, ch0 = 0x0006, rest negative -> out_score=2 (0x006>>1=3, +1=4, >>1=2), out_class=0.
5. Two back-to-back 4x4 frames -> out_frame_done pulses exactly at outputs 16 and 32. With HIST_EN and pixels alternating class 0/1: out_hist gives 8/8/0..., out_hist_valid one cycle after each pulse.
6. rst asserted at pixel 9 of a frame -> all outputs 0 immediately, no frame_done pulse. The next frame's first output appears 5 cycles after its first enable.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared helpers for the CNN output stages: ceil-log2, default fixed-point format,
// and the signed fixed-point to saturated unsigned score conversion.
package cnn_pkg;

  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) result = i + 1;
    return result;
  endfunction

  localparam int DEF_UNITS     = 12;
  localparam int DEF_INT_BITW  = 5;
  localparam int DEF_FRAC_BITW = 8;
  localparam int DEF_UINT_BITW = 8;
  localparam int FIXED_BITW    = DEF_INT_BITW + DEF_FRAC_BITW;
  localparam int TREE_DEPTH    = log2(DEF_UNITS);

  // Negative values clamp to zero; extra fraction bits are rounded half up
  // before saturating to the all-ones score.
  function automatic logic [63:0] fixed_to_uint(input logic signed [63:0] value,
                                                input int frac_bitw,
                                                input int uint_bitw);
    logic signed [63:0] rounded;
    logic [63:0]        max_score;
    int                 shift;
    max_score = (64'd1 << uint_bitw) - 64'd1;
    shift     = (frac_bitw > uint_bitw) ? (frac_bitw - uint_bitw - 1) : 0;
    rounded   = value;
    if (frac_bitw > uint_bitw)
      rounded = ((value >>> shift) + 64'sd1) >>> 1;
    if (value < 0)
      return 64'd0;
    if (rounded > $signed(max_score))
      return max_score;
    return rounded;
  endfunction

endpackage

// File: rtl/argmax_node.sv
// One registered comparator of the argmax tree; the lo pair always carries the
// lower channel indices, so keeping it on equal values gives the lower-index tie rule.
module argmax_node
  import cnn_pkg::*;
#(
  parameter int VAL_BITW = FIXED_BITW,
  parameter int IDX_BITW = TREE_DEPTH
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic signed [VAL_BITW-1:0] lo_val,
  input  logic        [IDX_BITW-1:0] lo_idx,
  input  logic signed [VAL_BITW-1:0] hi_val,
  input  logic        [IDX_BITW-1:0] hi_idx,
  output logic signed [VAL_BITW-1:0] win_val,
  output logic        [IDX_BITW-1:0] win_idx
);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      win_val <= '0;
      win_idx <= '0;
    end else if (hi_val > lo_val) begin
      win_val <= hi_val;
      win_idx <= hi_idx;
    end else begin
      win_val <= lo_val;
      win_idx <= lo_idx;
    end
  end

endmodule

// File: rtl/delay.sv
// Generic resettable shift-register delay line used to carry tags alongside data.
module delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] stage [0:DEPTH-1];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_data = stage[DEPTH-1];

endmodule

// File: rtl/itgnet_head.sv
// Per-pixel output head: registered argmax tree over UNITS signed features plus a
// saturated confidence score and frame-end pulse. Define ITGNET_HEAD_HIST_EN for per-class histograms.
module itgnet_head
  import cnn_pkg::*;
#(
  parameter int W_HEIGHT  = 480,
  parameter int W_WIDTH   = 640,
  parameter int UNITS     = DEF_UNITS,
  parameter int INT_BITW  = DEF_INT_BITW,
  parameter int FRAC_BITW = DEF_FRAC_BITW,
  parameter int UINT_BITW = DEF_UINT_BITW,
  localparam int FEAT_BITW  = INT_BITW + FRAC_BITW,
  localparam int VCNT_BITW  = log2(W_HEIGHT),
  localparam int HCNT_BITW  = log2(W_WIDTH),
  localparam int CLASS_BITW = log2(UNITS)
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         in_enable,
  input  logic [0:FEAT_BITW*UNITS-1]   in_feat,
  input  logic [VCNT_BITW-1:0]         in_vcnt,
  input  logic [HCNT_BITW-1:0]         in_hcnt,
  output logic                         out_enable,
  output logic [CLASS_BITW-1:0]        out_class,
  output logic [UINT_BITW-1:0]         out_score,
  output logic [VCNT_BITW-1:0]         out_vcnt,
  output logic [HCNT_BITW-1:0]         out_hcnt,
  output logic                         out_frame_done
`ifdef ITGNET_HEAD_HIST_EN
  ,
  output logic [UNITS*log2(W_HEIGHT*W_WIDTH+1)-1:0] out_hist,
  output logic                                      out_hist_valid
`endif
);

  localparam int DEPTH    = log2(UNITS);
  localparam int LEAVES   = 1 << DEPTH;
  localparam int LATENCY  = DEPTH + 1;
  localparam int TAG_BITW = 1 + VCNT_BITW + HCNT_BITW;

  // Heap-ordered tree: node i compares children 2i and 2i+1, leaves sit at LEAVES..2*LEAVES-1.
  logic signed [FEAT_BITW-1:0]  node_val [1:2*LEAVES-1];
  logic        [CLASS_BITW-1:0] node_idx [1:2*LEAVES-1];

  genvar g;
  generate
    for (g = 0; g < LEAVES; g++) begin : g_leaf
      if (g < UNITS) begin : g_real
        assign node_val[LEAVES+g] = in_feat[g*FEAT_BITW +: FEAT_BITW];
      end else begin : g_pad
        assign node_val[LEAVES+g] = {1'b1, {(FEAT_BITW-1){1'b0}}};
      end
      assign node_idx[LEAVES+g] = CLASS_BITW'(g);
    end

    for (g = 1; g < LEAVES; g++) begin : g_node
      argmax_node #(
        .VAL_BITW(FEAT_BITW),
        .IDX_BITW(CLASS_BITW)
      ) u_node (
        .clock  (clock),
        .rst    (rst),
        .lo_val (node_val[2*g]),
        .lo_idx (node_idx[2*g]),
        .hi_val (node_val[2*g+1]),
        .hi_idx (node_idx[2*g+1]),
        .win_val(node_val[g]),
        .win_idx(node_idx[g])
      );
    end
  endgenerate

  logic signed [63:0] root_ext;
  assign root_ext = {{(64-FEAT_BITW){node_val[1][FEAT_BITW-1]}}, node_val[1]};

  // Final stage turns the winning fixed-point value into the unsigned score.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_class <= '0;
      out_score <= '0;
    end else begin
      out_class <= node_idx[1];
      out_score <= UINT_BITW'(fixed_to_uint(root_ext, FRAC_BITW, UINT_BITW));
    end
  end

  logic [TAG_BITW-1:0] tag_in;
  logic [TAG_BITW-1:0] tag_out;

  assign tag_in = {in_enable, in_vcnt, in_hcnt};

  delay #(
    .WIDTH(TAG_BITW),
    .DEPTH(LATENCY)
  ) u_tag_delay (
    .clock   (clock),
    .rst     (rst),
    .in_data (tag_in),
    .out_data(tag_out)
  );

  assign {out_enable, out_vcnt, out_hcnt} = tag_out;

  assign out_frame_done = out_enable
                       && (out_vcnt == VCNT_BITW'(W_HEIGHT - 1))
                       && (out_hcnt == HCNT_BITW'(W_WIDTH - 1));

`ifdef ITGNET_HEAD_HIST_EN
  localparam int CNT_BITW = log2(W_HEIGHT * W_WIDTH + 1);

  logic [CNT_BITW-1:0] hist_cnt [0:UNITS-1];

  // On the frame-end pixel the snapshot includes that pixel and the counters restart at 0.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < UNITS; c++) hist_cnt[c] <= '0;
      out_hist       <= '0;
      out_hist_valid <= 1'b0;
    end else begin
      out_hist_valid <= out_frame_done;
      for (int c = 0; c < UNITS; c++) begin
        if (out_frame_done) begin
          out_hist[(UNITS-c)*CNT_BITW-1 -: CNT_BITW] <=
            hist_cnt[c] + CNT_BITW'(out_class == CLASS_BITW'(c));
          hist_cnt[c] <= '0;
        end else if (out_enable && (out_class == CLASS_BITW'(c))) begin
          hist_cnt[c] <= hist_cnt[c] + CNT_BITW'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_itgnet_head.sv
// Self-checking bench for itgnet_head on a 4x4 frame: directed cases, randomized
// pixels against a plain argmax/score model, a FRAC=10 instance, framing and reset.
module tb_itgnet_head;

  localparam int UNITS     = 12;
  localparam int UINT_BITW = 8;
  localparam int W_HEIGHT  = 4;
  localparam int W_WIDTH   = 4;
  localparam int FB        = 13;
  localparam int FB10      = 15;
  localparam int LAT       = 5;
  localparam int CW        = 4;
  localparam int PW        = 2;
  localparam int CNT_BITW  = 5;

  logic                 clock     = 1'b0;
  logic                 rst       = 1'b0;
  logic                 in_enable = 1'b0;
  logic [0:FB*UNITS-1]  in_feat   = '0;
  logic [0:FB10*UNITS-1] in_feat10 = '0;
  logic [PW-1:0]        in_vcnt   = '0;
  logic [PW-1:0]        in_hcnt   = '0;

  logic                 out_enable, out_frame_done;
  logic [CW-1:0]        out_class;
  logic [7:0]           out_score;
  logic [PW-1:0]        out_vcnt, out_hcnt;
  logic                 out_enable10, out_frame_done10;
  logic [CW-1:0]        out_class10;
  logic [7:0]           out_score10;
  logic [PW-1:0]        out_vcnt10, out_hcnt10;
`ifdef ITGNET_HEAD_HIST_EN
  logic [UNITS*CNT_BITW-1:0] out_hist, out_hist10;
  logic                      out_hist_valid, out_hist_valid10;
`endif

  itgnet_head #(
    .W_HEIGHT(W_HEIGHT), .W_WIDTH(W_WIDTH), .UNITS(UNITS),
    .INT_BITW(5), .FRAC_BITW(8), .UINT_BITW(UINT_BITW)
  ) dut (
    .clock(clock), .rst(rst), .in_enable(in_enable), .in_feat(in_feat),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(out_enable),
    .out_class(out_class), .out_score(out_score), .out_vcnt(out_vcnt),
    .out_hcnt(out_hcnt), .out_frame_done(out_frame_done)
`ifdef ITGNET_HEAD_HIST_EN
    , .out_hist(out_hist), .out_hist_valid(out_hist_valid)
`endif
  );

  itgnet_head #(
    .W_HEIGHT(W_HEIGHT), .W_WIDTH(W_WIDTH), .UNITS(UNITS),
    .INT_BITW(5), .FRAC_BITW(10), .UINT_BITW(UINT_BITW)
  ) dut10 (
    .clock(clock), .rst(rst), .in_enable(in_enable), .in_feat(in_feat10),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(out_enable10),
    .out_class(out_class10), .out_score(out_score10), .out_vcnt(out_vcnt10),
    .out_hcnt(out_hcnt10), .out_frame_done(out_frame_done10)
`ifdef ITGNET_HEAD_HIST_EN
    , .out_hist(out_hist10), .out_hist_valid(out_hist_valid10)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit en;
    int cls;
    int score;
    int v;
    int h;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   fv [UNITS];
  int   cur_frac = 8;
  exp_t exp_q [$];

  // Reference: first channel holding the maximum, then round-half-up and clamp.
  function automatic exp_t model(input bit en, input int v, input int h);
    exp_t r;
    int   best;
    int   k;
    best = 0;
    for (int c = 1; c < UNITS; c++)
      if (fv[c] > fv[best]) best = c;
    r.en  = en;
    r.v   = v;
    r.h   = h;
    r.cls = best;
    k     = cur_frac - UINT_BITW;
    if (fv[best] < 0)  r.score = 0;
    else if (k == 0)   r.score = fv[best];
    else               r.score = (fv[best] + (1 << (k - 1))) / (1 << k);
    if (r.score > (1 << UINT_BITW) - 1) r.score = (1 << UINT_BITW) - 1;
    return r;
  endfunction

  task automatic rand_feats(input int fbits);
    int lim;
    lim = 1 << (fbits - 1);
    for (int c = 0; c < UNITS; c++)
      case ($urandom_range(0, 2))
        0:       fv[c] = int'($urandom_range(0, 2 * lim - 1)) - lim;
        1:       fv[c] = (int'($urandom_range(0, 4)) - 2) * 64;
        default: fv[c] = int'($urandom_range(0, 700));
      endcase
  endtask

  task automatic drive(input bit en, input int v, input int h);
    in_enable = en;
    in_vcnt   = PW'(v);
    in_hcnt   = PW'(h);
    for (int c = 0; c < UNITS; c++) begin
      in_feat[c*FB +: FB]       = FB'(fv[c]);
      in_feat10[c*FB10 +: FB10] = FB10'(fv[c]);
    end
    exp_q.push_back(model(en, v, h));
    @(posedge clock);
    #1;
  endtask

  task automatic flush();
    for (int c = 0; c < UNITS; c++) fv[c] = 0;
    for (int i = 0; i < LAT + 1; i++) drive(1'b0, 0, 0);
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++; if (out_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_en: got %0b, expected 0", out_enable); end
    n_cmp++; if (out_class !== '0) begin n_bad++; $display("[TB] FAIL reset_class: got %0d, expected 0", out_class); end
    n_cmp++; if (out_score !== '0) begin n_bad++; $display("[TB] FAIL reset_score: got %0d, expected 0", out_score); end
    n_cmp++; if (out_vcnt !== '0 || out_hcnt !== '0) begin n_bad++; $display("[TB] FAIL reset_coord: got %0d/%0d, expected 0/0", out_vcnt, out_hcnt); end
    n_cmp++; if (out_frame_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_fd: got %0b, expected 0", out_frame_done); end
    @(posedge clock);
    #1;
    rst = 1'b0;
    flush();
  endtask

  task automatic test_directed();
    int exp_cls [3];
    int exp_score [3];
    exp_cls   = '{7, 3, 11};
    exp_score = '{64, 255, 0};
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < UNITS; c++) fv[c] = (t == 2) ? -256 : 0;
      case (t)
        0:       fv[7] = 'h40;
        1:       begin fv[3] = 'h100; fv[9] = 'h100; end
        default: fv[11] = -1;
      endcase
      drive(1'b1, t + 1, 3 - t);
      for (int c = 0; c < UNITS; c++) fv[c] = 0;
      for (int k = 1; k < LAT; k++) begin
        drive(1'b0, 0, 0);
        if (k == LAT - 2) begin
          n_cmp++; if (out_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL dir_early_en case %0d: got %0b, expected 0", t, out_enable); end
        end
      end
      n_cmp++; if (out_enable !== 1'b1) begin n_bad++; $display("[TB] FAIL dir_en case %0d: got %0b, expected 1", t, out_enable); end
      n_cmp++; if (out_class !== CW'(exp_cls[t])) begin n_bad++; $display("[TB] FAIL dir_class case %0d: got %0d, expected %0d", t, out_class, exp_cls[t]); end
      n_cmp++; if (out_score !== 8'(exp_score[t])) begin n_bad++; $display("[TB] FAIL dir_score case %0d: got %0d, expected %0d", t, out_score, exp_score[t]); end
      n_cmp++; if (out_vcnt !== PW'(t + 1) || out_hcnt !== PW'(3 - t)) begin n_bad++; $display("[TB] FAIL dir_coord case %0d: got %0d/%0d, expected %0d/%0d", t, out_vcnt, out_hcnt, t + 1, 3 - t); end
    end
    flush();
  endtask

  task automatic test_random();
    exp_t e;
    cur_frac = 8;
    for (int i = 0; i < 300; i++) begin
      rand_feats(FB);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (exp_q.size() == LAT) begin
        e = exp_q.pop_front();
        n_cmp++; if (out_enable !== e.en) begin n_bad++; $display("[TB] FAIL rand_en: got %0b, expected %0b", out_enable, e.en); end
        n_cmp++; if (out_frame_done !== (e.en && e.v == W_HEIGHT - 1 && e.h == W_WIDTH - 1)) begin n_bad++; $display("[TB] FAIL rand_fd: got %0b at %0d/%0d", out_frame_done, e.v, e.h); end
        if (e.en) begin
          n_cmp++; if (out_class !== CW'(e.cls)) begin n_bad++; $display("[TB] FAIL rand_class: got %0d, expected %0d", out_class, e.cls); end
          n_cmp++; if (out_score !== 8'(e.score)) begin n_bad++; $display("[TB] FAIL rand_score: got %0d, expected %0d", out_score, e.score); end
          n_cmp++; if (out_vcnt !== PW'(e.v) || out_hcnt !== PW'(e.h)) begin n_bad++; $display("[TB] FAIL rand_coord: got %0d/%0d, expected %0d/%0d", out_vcnt, out_hcnt, e.v, e.h); end
        end
      end
    end
    flush();
  endtask

  task automatic test_frac10();
    exp_t e;
    cur_frac = 10;
    for (int c = 0; c < UNITS; c++) fv[c] = -100;
    fv[0] = 6;
    drive(1'b1, 1, 2);
    for (int c = 0; c < UNITS; c++) fv[c] = 0;
    for (int k = 1; k < LAT; k++) drive(1'b0, 0, 0);
    n_cmp++; if (out_enable10 !== 1'b1) begin n_bad++; $display("[TB] FAIL f10_dir_en: got %0b, expected 1", out_enable10); end
    n_cmp++; if (out_class10 !== 4'd0) begin n_bad++; $display("[TB] FAIL f10_dir_class: got %0d, expected 0", out_class10); end
    n_cmp++; if (out_score10 !== 8'd2) begin n_bad++; $display("[TB] FAIL f10_dir_score: got %0d, expected 2", out_score10); end
    flush();
    for (int i = 0; i < 200; i++) begin
      rand_feats(FB10);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (exp_q.size() == LAT) begin
        e = exp_q.pop_front();
        n_cmp++; if (out_enable10 !== e.en) begin n_bad++; $display("[TB] FAIL f10_en: got %0b, expected %0b", out_enable10, e.en); end
        n_cmp++; if (out_frame_done10 !== (e.en && e.v == W_HEIGHT - 1 && e.h == W_WIDTH - 1)) begin n_bad++; $display("[TB] FAIL f10_fd: got %0b at %0d/%0d", out_frame_done10, e.v, e.h); end
        if (e.en) begin
          n_cmp++; if (out_class10 !== CW'(e.cls)) begin n_bad++; $display("[TB] FAIL f10_class: got %0d, expected %0d", out_class10, e.cls); end
          n_cmp++; if (out_score10 !== 8'(e.score)) begin n_bad++; $display("[TB] FAIL f10_score: got %0d, expected %0d", out_score10, e.score); end
          n_cmp++; if (out_vcnt10 !== PW'(e.v) || out_hcnt10 !== PW'(e.h)) begin n_bad++; $display("[TB] FAIL f10_coord: got %0d/%0d, expected %0d/%0d", out_vcnt10, out_hcnt10, e.v, e.h); end
        end
      end
    end
    cur_frac = 8;
    flush();
  endtask

  task automatic test_back_to_back();
    int n_out, n_pulse, n_hv, pulse_cyc;
    int pulse_at [2];
    n_out = 0; n_pulse = 0; n_hv = 0; pulse_cyc = -10;
    pulse_at = '{-1, -1};
    for (int i = 0; i < 32 + LAT + 2; i++) begin
      for (int c = 0; c < UNITS; c++) fv[c] = 0;
      if (i < 32) begin
        fv[i % 2] = 64;
        drive(1'b1, (i % 16) / 4, i % 4);
      end else begin
        drive(1'b0, 0, 0);
      end
`ifdef ITGNET_HEAD_HIST_EN
      if (out_hist_valid) begin
        n_hv++;
        n_cmp++; if (i + 1 != pulse_cyc + 1) begin n_bad++; $display("[TB] FAIL hist_valid_timing: got cycle %0d, expected %0d", i + 1, pulse_cyc + 1); end
        n_cmp++; if (out_hist[UNITS*CNT_BITW-1 -: CNT_BITW] !== 5'd8) begin n_bad++; $display("[TB] FAIL hist_c0: got %0d, expected 8", out_hist[UNITS*CNT_BITW-1 -: CNT_BITW]); end
        n_cmp++; if (out_hist[(UNITS-1)*CNT_BITW-1 -: CNT_BITW] !== 5'd8) begin n_bad++; $display("[TB] FAIL hist_c1: got %0d, expected 8", out_hist[(UNITS-1)*CNT_BITW-1 -: CNT_BITW]); end
        n_cmp++; if (out_hist[(UNITS-2)*CNT_BITW-1 -: CNT_BITW] !== 5'd0) begin n_bad++; $display("[TB] FAIL hist_c2: got %0d, expected 0", out_hist[(UNITS-2)*CNT_BITW-1 -: CNT_BITW]); end
      end
`endif
      if (out_enable) n_out++;
      if (out_frame_done) begin
        if (n_pulse < 2) pulse_at[n_pulse] = n_out;
        n_pulse++;
        pulse_cyc = i + 1;
      end
    end
    n_cmp++; if (n_out != 32) begin n_bad++; $display("[TB] FAIL b2b_outputs: got %0d, expected 32", n_out); end
    n_cmp++; if (n_pulse != 2) begin n_bad++; $display("[TB] FAIL b2b_pulses: got %0d, expected 2", n_pulse); end
    n_cmp++; if (pulse_at[0] != 16) begin n_bad++; $display("[TB] FAIL b2b_first_pulse: got output %0d, expected 16", pulse_at[0]); end
    n_cmp++; if (pulse_at[1] != 32) begin n_bad++; $display("[TB] FAIL b2b_second_pulse: got output %0d, expected 32", pulse_at[1]); end
`ifdef ITGNET_HEAD_HIST_EN
    n_cmp++; if (n_hv != 2) begin n_bad++; $display("[TB] FAIL hist_valid_count: got %0d, expected 2", n_hv); end
`endif
    flush();
  endtask

  task automatic test_reset_mid();
    int first_cyc, n_pulse;
    for (int p = 0; p < 9; p++) begin
      rand_feats(FB);
      drive(1'b1, p / 4, p % 4);
    end
    n_cmp++; if (out_enable !== 1'b1) begin n_bad++; $display("[TB] FAIL pre_rst_en: got %0b, expected 1", out_enable); end
    in_enable = 1'b1;
    in_vcnt   = 2'd2;
    in_hcnt   = 2'd1;
    rst       = 1'b1;
    #1;
    n_cmp++; if (out_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_en: got %0b, expected 0", out_enable); end
    n_cmp++; if (out_class !== '0 || out_score !== '0) begin n_bad++; $display("[TB] FAIL midrst_data: got %0d/%0d, expected 0/0", out_class, out_score); end
    n_cmp++; if (out_vcnt !== '0 || out_hcnt !== '0) begin n_bad++; $display("[TB] FAIL midrst_coord: got %0d/%0d, expected 0/0", out_vcnt, out_hcnt); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 0, 0);
      n_cmp++; if (out_frame_done !== 1'b0 || out_enable !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_hold: got en=%0b fd=%0b, expected 0/0", out_enable, out_frame_done); end
    end
    rst = 1'b0;
    drive(1'b0, 0, 0);
    drive(1'b0, 0, 0);
    exp_q.delete();
    first_cyc = -1;
    n_pulse   = 0;
    for (int i = 0; i < 16 + LAT + 2; i++) begin
      rand_feats(FB);
      if (i < 16) drive(1'b1, i / 4, i % 4);
      else        drive(1'b0, 0, 0);
      if (out_enable && first_cyc < 0) first_cyc = i + 1;
      if (out_frame_done) n_pulse++;
    end
    n_cmp++; if (first_cyc != LAT) begin n_bad++; $display("[TB] FAIL postrst_latency: got %0d, expected %0d", first_cyc, LAT); end
    n_cmp++; if (n_pulse != 1) begin n_bad++; $display("[TB] FAIL postrst_pulses: got %0d, expected 1", n_pulse); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_frac10();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
